bus_arbiter: RTL

//  Round-robin arbiter that shares the chip's single internal bus between up to
//  NUM_MASTER requesters (CPU data port, UART DMA, GPIO DMA, debug).

---
 rtl/bus_arbiter_if.sv | 30 +++
 rtl/bus_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between the bus masters and the
// round-robin bus arbiter.
//   req       master -> arbiter  per-master request, held for the whole transfer
//   bus_lock  master -> arbiter  current owner forbids preemption (atomic sequence)
//   grant     arbiter -> master  one-hot registered grant
//   owner     arbiter -> master  index of the granted master (bus mux select)
//   busy      arbiter -> master  1 while any grant is active
//   timeout   arbiter -> master  1-cycle pulse when the watchdog revokes a grant
// Modports: master (requester side), slave (arbiter side).
interface bus_arbiter_if #(
  parameter int NUM_MASTER = 4,
  parameter int IDX_W      = 2
);
  logic [NUM_MASTER-1:0] req;
  logic                  bus_lock;
  logic [NUM_MASTER-1:0] grant;
  logic [IDX_W-1:0]      owner;
  logic                  busy;
  logic                  timeout;

  modport master (
    output req, bus_lock,
    input  grant, owner, busy, timeout
  );

  modport slave (
    input  req, bus_lock,
    output grant, owner, busy, timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing the single internal bus between
// up to NUM_MASTER requesters. Non-preemptive, one dead (HANDOVER) cycle
// between owners so the mux/tri-state handover is clean.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    bus_arbiter_if.slave (req, bus_lock in; grant, owner, busy, timeout out)
// Optional feature: define BUS_ARB_TIMEOUT_EN to add the ownership watchdog
// (TIMEOUT_CYCLES limit, overridden by bus_lock). Without it timeout is 0
// and bus_lock is ignored.
module bus_arbiter #(
  parameter int NUM_MASTER     = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    HANDOVER = 2'd2
  } state_e;

  // After reset the scan starts just past NUM_MASTER-1, i.e. at master 0.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTER - 1);

  state_e                state_q, state_d;
  logic [NUM_MASTER-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_q,  last_d;

  logic                  win_valid;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      scan_idx;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic          unused_bus_lock;
  assign unused_bus_lock = bus.bus_lock;
`endif

  // Round-robin winner: first set req bit scanning last+1 .. last+NUM_MASTER
  // modulo NUM_MASTER, so the previous owner is checked last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 1; i <= NUM_MASTER; i++) begin
      scan_idx = IDX_W'((32'(last_q) + i) % NUM_MASTER);
      if (!win_valid && bus.req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      // HANDOVER always lasts exactly one cycle; IDLE waits for a request.
      IDLE, HANDOVER: begin
        if (win_valid) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          last_d           = win_idx;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d            = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[owner_q]) begin
          grant_d = '0;
          state_d = HANDOVER;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        // cnt_q == CNT_LAST marks the TIMEOUT_CYCLES-th grant cycle; while
        // locked the counter parks at CNT_SAT and revokes once lock drops.
        else if ((cnt_q >= CNT_LAST) && !bus.bus_lock) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = HANDOVER;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = |grant_q;

endmodule
